riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Parametrised instruction fetch front-end that replaces the single-shot fetch state inside the RISC-V core.
- Prefetches 32-bit words from the instruction memory bus into a halfword queue of configurable depth.
- Reassembles 16/32-bit (compressed/full) instruction codes across word boundaries and hands them to the decode/execute stage over a valid/ready handshake.
- Supports PC redirect (branch/jump/trap) with queue flush and discard of in-flight responses.

Parameters:
- ADDRESS_SIZE, 14, number of word-address lines on the memory bus (32-bit words).
- RESET_PC_ADDRESS, 0, byte address fetched first after reset; bit 0 must be 0.
- QUEUE_HALVES, 8, halfword queue capacity; even, >=4.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- memAddress  out  ADDRESS_SIZE  word address of the current read.
- memStrobe  out  1  read request; held until memReady.
- memReady  in  1  memory completed the read; memData valid this cycle.
- memData  in  32  read data, little-endian.
- insnValid  out  1  insnCode/insnPc hold a complete instruction.
- insnReady  in  1  consumer accepts the instruction this cycle.
- insnCode  out  32  raw code; compressed codes zero-extended in [31:16].
- insnCompressed  out  1  insnCode[1:0] != 2'b11.
- insnPc  out  ADDRESS_SIZE+2  byte address of the instruction.
- redirectValid  in  1  load new PC, flush the queue.
- redirectPc  in  ADDRESS_SIZE+2  new byte PC.
- fetchFault  out  1  sticky: redirect to an odd byte address.

Behaviour:
- **Reset:** memStrobe=0, insnValid=0, fetchFault=0, queue empty, discard=0. Fetch PC (halfword units, ADDRESS_SIZE+1 bits) = RESET_PC_ADDRESS>>1; head PC = same.
- **Request issue:**
  - If memStrobe=0, discard=0, fault=0 and free slots >= 2 (>= 1 when fetch PC bit0=1), drive memAddress=fetchPc[ADDRESS_SIZE:1] and set memStrobe=1 next cycle. The first strobe therefore appears 1 cycle after reset deasserts.
  - At most one outstanding request. memAddress is stable while memStrobe=1.
- **Response (memStrobe=1 and memReady=1):**
  - memStrobe drops next cycle.
  - If discard=1: drop the data and clear discard.
  - Otherwise, fetch PC even: push memData[15:0] then memData[31:16], and fetch PC += 2.
  - Otherwise, fetch PC odd: push memData[31:16] only, and fetch PC += 1.
  - Fetch PC wraps modulo 2^(ADDRESS_SIZE+1).
  - Peak throughput: one word every 2 cycles with a zero-wait memory.
- **Output:**
  - insnValid = queue non-empty AND (head[1:0] != 2'b11 OR count >= 2). Combinational from queue state.
  - insnCode = {head+1, head} when full-size, else {16'h0, head}.
  - insnPc = headPc<<1.
- **Consume (insnValid & insnReady):** pop 1 or 2 halfwords; headPc += 1 or 2 (wraps). Push and pop in the same cycle are both honoured; count is updated by net change.
- **Partial instruction:** a 32-bit code with only its low half queued keeps insnValid=0 until the next word arrives. This replaces the old hasHalfInsn logic.
- **Redirect (priority over consume and push in the same cycle):**
  - Queue flushed (count=0); fetch PC and headPc = redirectPc>>1; insnValid=0 next cycle.
  - If memStrobe=1 and memReady=0 at redirect: set discard=1 and keep memStrobe high until memReady. The old address is held and the bus is never aborted.
  - If memReady=1 in the redirect cycle: that data is dropped and discard stays 0.
- **Fault:** redirectPc[0]=1 sets fetchFault=1.
  - New requests stop and insnValid is forced to 0.
  - An outstanding request completes and is dropped.
  - Cleared only by reset.
- **Full queue:** no request issued; an in-flight response always fits by the issue rule.
- **Reset mid-request:** memStrobe drops immediately next cycle; the memory side is required to tolerate the abandoned strobe.

Test Plan:
1. Reset, PC=0; memory words 0x00A00093, 0x4501_0505 (c.addi, c.li), zero-wait, insnReady=1 → insnCode 0x00A00093 @0, then 0x00000505 @4, then 0x00004501 @6.
2. Redirect to 0x2 with word0 = 0x0093_xxxx and word1 = 0x????_00A0 → one strobe at address 0 (high half pushed), one at address 1; insnValid only after the second response; insnCode=0x00A00093, insnPc=0x2.
3. Hold insnReady=0 with all-compressed memory, QUEUE_HALVES=8 → exactly 4 strobes, then memStrobe stays 0; releasing insnReady resumes fetch with no lost or duplicated halfwords (PCs 0,2,4,…).
4. Memory with 3-cycle latency; redirectValid to 0x100 one cycle after strobe → strobe held to completion, stale data discarded; next strobe address 0x40; first insnPc=0x100.
5. redirectPc=0x101 → fetchFault=1 next cycle; insnValid=0, no further strobes until reset; after reset fetch restarts at RESET_PC_ADDRESS.
6. ADDRESS_SIZE=4, fetch at the last word (byte 0x3C) → next memAddress=0, and insnPc wraps 0x3C, 0x3E, 0x00.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front-end: prefetches 32-bit words into a halfword queue and reassembles 16/32-bit codes.
// One outstanding read; issue stalls while the queue lacks room, decode is fed over insnValid/insnReady.
module riscv_fetch_unit #(
   parameter int          ADDRESS_SIZE     = 14,
   parameter int unsigned RESET_PC_ADDRESS = 0,
   parameter int          QUEUE_HALVES     = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic [ADDRESS_SIZE-1:0] memAddress,
   output logic                    memStrobe,
   input  logic                    memReady,
   input  logic [31:0]             memData,
   output logic                    insnValid,
   input  logic                    insnReady,
   output logic [31:0]             insnCode,
   output logic                    insnCompressed,
   output logic [ADDRESS_SIZE+1:0] insnPc,
   input  logic                    redirectValid,
   input  logic [ADDRESS_SIZE+1:0] redirectPc,
   output logic                    fetchFault
);
   localparam int PW = $clog2(QUEUE_HALVES);
   localparam int CW = $clog2(QUEUE_HALVES + 1);
   localparam int HW = ADDRESS_SIZE + 1;
   localparam logic [HW-1:0] RESET_HPC = HW'(RESET_PC_ADDRESS >> 1);
   localparam logic [CW-1:0] CAPACITY  = CW'(QUEUE_HALVES);

   logic [15:0]             queue_q [QUEUE_HALVES];
   logic [15:0]             queue_d [QUEUE_HALVES];
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [HW-1:0]           fetch_pc_q, fetch_pc_d;
   logic [HW-1:0]           head_pc_q, head_pc_d;
   logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
   logic                    mem_strobe_q, mem_strobe_d;
   logic                    discard_q, discard_d;
   logic                    fault_q, fault_d;

   logic [15:0]   head_half;
   logic [15:0]   next_half;
   logic          head_full;
   logic          resp;
   logic          consume;
   logic [1:0]    push_n;
   logic [1:0]    pop_n;
   logic [CW-1:0] free_slots;
   logic [CW-1:0] need_slots;

   // Circular pointer advance; the queue depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input logic [1:0] n);
      logic [PW:0] sum;
      sum = {1'b0, ptr} + (PW+1)'(n);
      if (sum >= (PW+1)'(QUEUE_HALVES)) begin
         sum = sum - (PW+1)'(QUEUE_HALVES);
      end
      return sum[PW-1:0];
   endfunction

   assign head_half      = queue_q[rd_ptr_q];
   assign next_half      = queue_q[ptr_add(rd_ptr_q, 2'd1)];
   assign head_full      = (head_half[1:0] == 2'b11);
   assign insnValid      = !fault_q && (count_q != '0) && (!head_full || count_q >= CW'(2));
   assign insnCode       = head_full ? {next_half, head_half} : {16'h0000, head_half};
   assign insnCompressed = !head_full;
   assign insnPc         = {head_pc_q, 1'b0};
   assign memAddress     = mem_addr_q;
   assign memStrobe      = mem_strobe_q;
   assign fetchFault     = fault_q;

   always_comb begin
      queue_d      = queue_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      fetch_pc_d   = fetch_pc_q;
      head_pc_d    = head_pc_q;
      mem_addr_d   = mem_addr_q;
      mem_strobe_d = mem_strobe_q;
      discard_d    = discard_q;
      fault_d      = fault_q;

      resp       = mem_strobe_q && memReady;
      consume    = insnValid && insnReady && !redirectValid;
      pop_n      = !consume ? 2'd0 : (head_full ? 2'd2 : 2'd1);
      push_n     = (resp && !discard_q && !fault_q && !redirectValid) ?
                   (fetch_pc_q[0] ? 2'd1 : 2'd2) : 2'd0;
      free_slots = CAPACITY - count_q;
      need_slots = fetch_pc_q[0] ? CW'(1) : CW'(2);

      if (resp) begin
         mem_strobe_d = 1'b0;
         discard_d    = 1'b0;
      end

      if (redirectValid) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirectPc[HW:1];
         head_pc_d  = redirectPc[HW:1];
         if (redirectPc[0]) begin
            fault_d = 1'b1;
         end
         // The bus is never aborted: a read still pending is completed and its data dropped.
         if (mem_strobe_q && !memReady) begin
            discard_d = 1'b1;
         end
      end else begin
         if (push_n == 2'd1) begin
            queue_d[wr_ptr_q] = memData[31:16];
         end else if (push_n == 2'd2) begin
            queue_d[wr_ptr_q]                 = memData[15:0];
            queue_d[ptr_add(wr_ptr_q, 2'd1)] = memData[31:16];
         end
         wr_ptr_d   = ptr_add(wr_ptr_q, push_n);
         rd_ptr_d   = ptr_add(rd_ptr_q, pop_n);
         fetch_pc_d = fetch_pc_q + HW'(push_n);
         head_pc_d  = head_pc_q + HW'(pop_n);
         count_d    = count_q + CW'(push_n) - CW'(pop_n);
      end

      // Room is reserved at issue time, so the response always fits when it lands.
      if (!mem_strobe_q && !discard_q && !fault_q && !redirectValid && free_slots >= need_slots) begin
         mem_strobe_d = 1'b1;
         mem_addr_d   = fetch_pc_q[HW-1:1];
      end
   end

   always_ff @(posedge clock) begin
      queue_q <= queue_d;
      if (reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         fetch_pc_q   <= RESET_HPC;
         head_pc_q    <= RESET_HPC;
         mem_addr_q   <= '0;
         mem_strobe_q <= 1'b0;
         discard_q    <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fetch_pc_q   <= fetch_pc_d;
         head_pc_q    <= head_pc_d;
         mem_addr_q   <= mem_addr_d;
         mem_strobe_q <= mem_strobe_d;
         discard_q    <= discard_d;
         fault_q      <= fault_d;
      end
   end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: instruction streams from a vector table checked through a scoreboard,
// plus hand-written redirect, backpressure, discard, fault and wrap sequences.
module tb_riscv_fetch_unit;
   typedef struct {
      logic        redir;
      logic [15:0] pc;
      logic [31:0] code;
   } vec_t;

   logic        clock         = 1'b0;
   logic        reset         = 1'b1;
   logic [13:0] memAddress;
   logic        memStrobe;
   logic        memReady      = 1'b0;
   logic [31:0] memData       = 32'h0;
   logic        insnValid;
   logic        insnReady     = 1'b0;
   logic [31:0] insnCode;
   logic        insnCompressed;
   logic [15:0] insnPc;
   logic        redirectValid = 1'b0;
   logic [15:0] redirectPc    = 16'h0;
   logic        fetchFault;

   int          vectors     = 0;
   int          miscompares = 0;
   vec_t        sb[$];
   logic [31:0] mem [0:16383];
   int          mem_lat  = 0;
   int          wait_cnt = 0;
   int          resp_cnt = 0;
   logic [13:0] last_addr = 14'h0;
   logic [13:0] prev_addr = 14'h0;

   riscv_fetch_unit #(
      .ADDRESS_SIZE    (14),
      .RESET_PC_ADDRESS(0),
      .QUEUE_HALVES    (8)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .memAddress    (memAddress),
      .memStrobe     (memStrobe),
      .memReady      (memReady),
      .memData       (memData),
      .insnValid     (insnValid),
      .insnReady     (insnReady),
      .insnCode      (insnCode),
      .insnCompressed(insnCompressed),
      .insnPc        (insnPc),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc),
      .fetchFault    (fetchFault)
   );

   always #5 clock = ~clock;

   // Memory model: answers a strobe after mem_lat idle cycles; ready lasts exactly one cycle.
   always @(negedge clock) begin
      if (reset || !memStrobe || memReady) begin
         memReady = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
         memReady  = 1'b1;
         memData   = mem[memAddress];
         resp_cnt++;
         prev_addr = last_addr;
         last_addr = memAddress;
      end else begin
         wait_cnt++;
      end
   end

   function automatic logic [15:0] hw(input logic [15:0] p);
      return {p[14:1], 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Compares any handshake about to be taken at the coming edge, then advances one cycle.
   task automatic tick();
      vec_t e;
      if (insnValid && insnReady && !redirectValid && !reset) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_insn: got pc 0x%04h code 0x%08h, expected no instruction", insnPc, insnCode);
         end else begin
            e = sb.pop_front();
            chk("insnPc", 32'(insnPc), 32'(e.pc));
            chk("insnCode", insnCode, e.code);
            chk("insnCompressed", 32'(insnCompressed), 32'(e.code[1:0] != 2'b11));
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 600) begin
         insnReady = ($urandom_range(0, 3) != 0);
         tick();
         budget++;
      end
      insnReady = 1'b0;
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d instructions still pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_redirect(input logic [15:0] pc);
      insnReady     = 1'b0;
      redirectPc    = pc;
      redirectValid = 1'b1;
      tick();
      redirectValid = 1'b0;
   endtask

   task automatic wait_idle();
      insnReady = 1'b0;
      repeat (40) tick();
   endtask

   initial begin
      vec_t vecs[$];
      int   n0;
      int   waited;
      int   strobes;

      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[14'h0000] = 32'h00A00093;
      mem[14'h0001] = 32'h45010505;
      mem[14'h0080] = 32'h00A00093;
      mem[14'h0081] = 32'h01130505;
      mem[14'h0082] = 32'h450100B0;
      mem[14'h0083] = 32'h002081B3;
      mem[14'h0084] = 32'h00018082;
      mem[14'h3FFF] = 32'h45010505;
      mem[14'h0040] = 32'h00C00213;
      for (int k = 0; k < 16; k++) begin
         mem[14'h0100 + k] = {hw(16'h0402 + 16'(4 * k)), hw(16'h0400 + 16'(4 * k))};
      end

      vecs.push_back('{1'b0, 16'h0000, 32'h00A00093});
      vecs.push_back('{1'b0, 16'h0004, 32'h00000505});
      vecs.push_back('{1'b0, 16'h0006, 32'h00004501});
      vecs.push_back('{1'b1, 16'h0200, 32'h00A00093});
      vecs.push_back('{1'b0, 16'h0204, 32'h00000505});
      vecs.push_back('{1'b0, 16'h0206, 32'h00B00113});
      vecs.push_back('{1'b0, 16'h020A, 32'h00004501});
      vecs.push_back('{1'b0, 16'h020C, 32'h002081B3});
      vecs.push_back('{1'b0, 16'h0210, 32'h00008082});
      vecs.push_back('{1'b0, 16'h0212, 32'h00000001});
      vecs.push_back('{1'b1, 16'h0206, 32'h00B00113});
      vecs.push_back('{1'b0, 16'h020A, 32'h00004501});
      vecs.push_back('{1'b0, 16'h020C, 32'h002081B3});
      vecs.push_back('{1'b1, 16'hFFFC, 32'h00000505});
      vecs.push_back('{1'b0, 16'hFFFE, 32'h00004501});
      vecs.push_back('{1'b0, 16'h0000, 32'h00A00093});

      // Reset state and first request
      repeat (3) tick();
      chk("reset_memStrobe", 32'(memStrobe), 32'd0);
      chk("reset_insnValid", 32'(insnValid), 32'd0);
      chk("reset_fetchFault", 32'(fetchFault), 32'd0);
      reset = 1'b0;
      tick();
      chk("first_strobe", 32'(memStrobe), 32'd1);
      chk("first_addr", 32'(memAddress), 32'h0);

      foreach (vecs[i]) begin
         if (vecs[i].redir) begin
            drain();
            mem_lat = $urandom_range(0, 2);
            do_redirect(vecs[i].pc);
         end
         sb.push_back(vecs[i]);
      end
      drain();
      mem_lat = 0;

      // Full-size instruction straddling a word boundary from an odd halfword start
      wait_idle();
      mem[0] = 32'h00935555;
      mem[1] = 32'h000100A0;
      do_redirect(16'h0002);
      waited = 0;
      while (!insnValid && waited < 20) begin
         tick();
         waited++;
      end
      chk("split_valid", 32'(insnValid), 32'd1);
      chk("split_prev_addr", 32'(prev_addr), 32'h0);
      chk("split_last_addr", 32'(last_addr), 32'h1);
      chk("split_code", insnCode, 32'h00A00093);
      chk("split_pc", 32'(insnPc), 32'h0002);
      mem[0] = 32'h00A00093;
      mem[1] = 32'h45010505;

      // Backpressure: queue of 8 halves fills after exactly 4 reads
      wait_idle();
      n0 = resp_cnt;
      do_redirect(16'h0400);
      repeat (30) tick();
      chk("bp_reads", 32'(resp_cnt - n0), 32'd4);
      chk("bp_strobe_idle", 32'(memStrobe), 32'd0);
      chk("bp_valid_held", 32'(insnValid), 32'd1);
      for (int k = 0; k < 16; k++) begin
         sb.push_back('{1'b0, 16'h0400 + 16'(2 * k), {16'h0000, hw(16'h0400 + 16'(2 * k))}});
      end
      drain();

      // Redirect while a slow read is outstanding: read held, data discarded
      wait_idle();
      mem_lat = 3;
      do_redirect(16'h0200);
      waited = 0;
      while (!memStrobe && waited < 10) begin
         tick();
         waited++;
      end
      chk("disc_first_addr", 32'(memAddress), 32'h80);
      do_redirect(16'h0100);
      chk("disc_strobe_held", 32'(memStrobe), 32'd1);
      chk("disc_addr_held", 32'(memAddress), 32'h80);
      chk("disc_no_valid", 32'(insnValid), 32'd0);
      waited = 0;
      while (memStrobe && waited < 10) begin
         tick();
         waited++;
      end
      waited = 0;
      while (!memStrobe && waited < 10) begin
         tick();
         waited++;
      end
      chk("disc_next_addr", 32'(memAddress), 32'h40);
      sb.push_back('{1'b0, 16'h0100, 32'h00C00213});
      drain();
      mem_lat = 0;

      // Odd redirect target: sticky fault, fetch stops until reset
      do_redirect(16'h0101);
      chk("fault_set", 32'(fetchFault), 32'd1);
      chk("fault_no_valid", 32'(insnValid), 32'd0);
      strobes = 0;
      insnReady = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick();
         if (k >= 6 && memStrobe) strobes++;
      end
      insnReady = 1'b0;
      chk("fault_no_strobes", 32'(strobes), 32'd0);
      chk("fault_sticky", 32'(fetchFault), 32'd1);
      reset = 1'b1;
      repeat (2) tick();
      chk("fault_cleared", 32'(fetchFault), 32'd0);
      reset = 1'b0;
      tick();
      chk("restart_strobe", 32'(memStrobe), 32'd1);
      chk("restart_addr", 32'(memAddress), 32'h0);
      for (int i = 0; i < 3; i++) sb.push_back(vecs[i]);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
